// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - batch front-end issuing consecutive fib jobs and queueing results
module fib_sequencer #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int COUNT_WIDTH  = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [INPUT_WIDTH-1:0]        n_first,
    input  logic [COUNT_WIDTH-1:0]        count,
    output logic                          busy,
    output logic                          done,
    output logic                          fib_go,
    output logic [INPUT_WIDTH-1:0]        fib_n,
    input  logic [OUTPUT_WIDTH-1:0]       fib_result,
    input  logic                          fib_overflow,
    input  logic                          fib_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INPUT_WIDTH-1:0]        out_n,
    output logic [OUTPUT_WIDTH-1:0]       out_result,
    output logic                          out_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = INPUT_WIDTH + OUTPUT_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] n_q, n_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   done_q, done_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   push, pop, go;

    assign pop = (level_q != '0) && out_ready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rem_d   = rem_q;
        done_d  = done_q;
        go      = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = n_first;
                    rem_d = count;
                    if (count == '0) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A slot reserved here cannot be lost before capture: only pops change level meanwhile.
                if (level_q != DEPTH_L || pop) begin
                    go      = 1'b1;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!fib_done) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (fib_done) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                push  = 1'b1;
                n_d   = n_q + INPUT_WIDTH'(1);
                rem_d = rem_q - COUNT_WIDTH'(1);
                if (rem_q > COUNT_WIDTH'(1)) begin
                    state_d = S_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (push) begin
            mem_d[wr_q] = {n_q, fib_result, fib_overflow};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage only; validity comes from level_q, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT_LOW) ||
                        (state_q == S_WAIT_HIGH) || (state_q == S_CAPTURE);
    assign done       = done_q;
    assign fib_go     = go;
    assign fib_n      = n_q;
    assign out_valid  = (level_q != '0);
    assign {out_n, out_result, out_overflow} = mem_q[rd_q];
    assign fifo_level = level_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// tb/tb_fib_sequencer.sv - self-checking bench for fib_sequencer with a latency-4 fib stub
module tb_fib_sequencer;
    localparam int IW    = 6;
    localparam int OW    = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] n_first = '0;
    logic [CW-1:0] count = '0;
    logic          busy, done, fib_go;
    logic [IW-1:0] fib_n;
    logic [OW-1:0] fib_result;
    logic          fib_overflow, fib_done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_n;
    logic [OW-1:0] out_result;
    logic          out_overflow;
    logic [3:0]    fifo_level;

    fib_sequencer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .n_first(n_first), .count(count),
        .busy(busy), .done(done), .fib_go(fib_go), .fib_n(fib_n),
        .fib_result(fib_result), .fib_overflow(fib_overflow), .fib_done(fib_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
        .out_result(out_result), .out_overflow(out_overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Stub fib: done drops after go, rises LAT cycles later; result=3n, overflow=(n>=47).
    logic [2:0] stub_cnt;
    logic       stub_act;
    always_ff @(posedge clk) begin
        if (rst) begin
            fib_done     <= 1'b0;
            stub_act     <= 1'b0;
            stub_cnt     <= '0;
            fib_result   <= '0;
            fib_overflow <= 1'b0;
        end else if (fib_go) begin
            fib_done     <= 1'b0;
            stub_act     <= 1'b1;
            stub_cnt     <= 3'(LAT - 1);
            fib_result   <= OW'(3 * int'(fib_n));
            fib_overflow <= (fib_n >= 6'd47);
        end else if (stub_act) begin
            if (stub_cnt == 3'd0) begin
                fib_done <= 1'b1;
                stub_act <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 3'd1;
            end
        end
    end

    typedef struct { int n; int res; bit ovf; } ent_t;
    typedef struct { int nf; int cnt; int mode; int exp_go; int exp_last_n; } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   go_cnt = 0;
    int   pops = 0;
    int   last_n = -1;
    int   ready_mode = 1;
    ent_t exp_q[$];
    vec_t vecs[6];

    task automatic check(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int expv);
        check(act == expv, name, act, expv);
    endtask

    task automatic monitor();
        bit            prev_go = 1'b0;
        bit            prev_stall = 1'b0;
        logic [IW-1:0] ph_n = '0;
        logic [OW-1:0] ph_r = '0;
        logic          ph_o = 1'b0;
        ent_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_go    = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (fib_go) begin
                    go_cnt++;
                    check_eq("go_width", int'(prev_go), 0);
                    check(fifo_level < 4'(DEPTH) || (out_valid && out_ready),
                          "go_when_full", int'(fifo_level), DEPTH - 1);
                end
                if (prev_stall)
                    check(out_valid && out_n == ph_n && out_result == ph_r && out_overflow == ph_o,
                          "head_stable", int'(out_n), int'(ph_n));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_out", int'(out_n), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(int'(out_n) == e.n && int'(out_result) == e.res && out_overflow == e.ovf,
                              $sformatf("out_entry n=%0d/%0d ovf=%0b/%0b result", out_n, e.n, out_overflow, e.ovf),
                              int'(out_result), e.res);
                        last_n = int'(out_n);
                        pops++;
                    end
                end
                prev_go    = fib_go;
                prev_stall = out_valid && !out_ready;
                ph_n       = out_n;
                ph_r       = out_result;
                ph_o       = out_overflow;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic do_start(input int nf, input int cnt);
        ent_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < cnt; i++) begin
            e.n   = (nf + i) % 64;
            e.res = 3 * e.n;
            e.ovf = (e.n >= 47);
            exp_q.push_back(e);
        end
        go_cnt  = 0;
        pops    = 0;
        last_n  = -1;
        start   = 1'b1;
        n_first = IW'(nf);
        count   = CW'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        while (!done && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check(done == 1'b1, "done_timeout", c, max_cyc);
    endtask

    task automatic drain(input int max_cyc);
        int c = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        @(negedge clk);
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("level_empty", int'(fifo_level), 0);
        check_eq("valid_empty", int'(out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_go"}, int'(fib_go), 0);
        check_eq({tag, "_fib_n"}, int'(fib_n), 0);
        check_eq({tag, "_out_valid"}, int'(out_valid), 0);
        check_eq({tag, "_level"}, int'(fifo_level), 0);
    endtask

    initial begin
        int c;
        int nf;
        int cnt;

        vecs[0] = '{5, 4, 1, 4, 8};
        vecs[1] = '{62, 3, 1, 3, 0};
        vecs[2] = '{0, 0, 1, 0, -1};
        vecs[3] = '{47, 1, 1, 1, 47};
        vecs[4] = '{60, 6, 2, 6, 1};
        vecs[5] = '{1, 9, 2, 9, 9};

        fork
            monitor();
            ready_drv();
        join_none

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // count=0: done within two cycles, no go, nothing queued
        ready_mode = 1;
        do_start(9, 0);
        c = 0;
        while (!done && c < 2) begin
            @(negedge clk);
            c++;
        end
        check_eq("zero_done", int'(done), 1);
        repeat (5) @(negedge clk);
        check_eq("zero_go", go_cnt, 0);
        check_eq("zero_valid", int'(out_valid), 0);

        for (int i = 0; i < 6; i++) begin
            ready_mode = vecs[i].mode;
            do_start(vecs[i].nf, vecs[i].cnt);
            wait_done(2000);
            drain(2000);
            check_eq($sformatf("vec%0d_go_count", i), go_cnt, vecs[i].exp_go);
            check_eq($sformatf("vec%0d_last_n", i), last_n, vecs[i].exp_last_n);
            check_eq($sformatf("vec%0d_busy", i), int'(busy), 0);
            check_eq($sformatf("vec%0d_done", i), int'(done), 1);
        end

        // Backpressure: issuing stalls with a full FIFO, then drains in order
        ready_mode = 0;
        do_start(10, 12);
        c = 0;
        while (fifo_level != 4'(DEPTH) && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (30) @(negedge clk);
        check_eq("full_level", int'(fifo_level), DEPTH);
        check_eq("full_go_count", go_cnt, DEPTH);
        check_eq("full_busy", int'(busy), 1);
        check_eq("full_done", int'(done), 0);
        ready_mode = 1;
        wait_done(2000);
        @(posedge clk);
        #1;
        check_eq("captured_at_done", pops + int'(fifo_level), 12);
        drain(2000);
        check_eq("full_total_go", go_cnt, 12);
        check_eq("full_last_n", last_n, 21);

        // Reset during the third job of a six-job batch
        ready_mode = 1;
        do_start(30, 6);
        c = 0;
        while (go_cnt < 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check_eq("third_go_seen", go_cnt, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        do_start(20, 3);
        wait_done(2000);
        drain(2000);
        check_eq("post_reset_go", go_cnt, 3);
        check_eq("post_reset_last_n", last_n, 22);

        // Random batches, random backpressure, start pulsed while busy
        for (int k = 0; k < 4; k++) begin
            nf  = $urandom_range(0, 63);
            cnt = $urandom_range(3, 14);
            ready_mode = 2;
            do_start(nf, cnt);
            repeat (3) @(posedge clk);
            #1;
            if (busy) begin
                start   = 1'b1;
                n_first = IW'($urandom_range(0, 63));
                count   = CW'($urandom_range(1, 255));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            wait_done(3000);
            drain(3000);
            check_eq($sformatf("rand%0d_go_count", k), go_cnt, cnt);
            check_eq($sformatf("rand%0d_last_n", k), last_n, (nf + cnt - 1) % 64);
            check_eq($sformatf("rand%0d_busy", k), int'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
